perif_uart: RTL

Memory-mapped UART peripheral that sits directly downstream of `control_UART_FSM`. It consumes the FSM's register writes (`wr`, `reg_sel`, 32-bit write data) and returns register contents on a 32-bit read bus. It serialises 8N1 frames onto `tx_o` and deserialises frames from `rx_i`. It exposes a send/received handshake through a 2-bit control register.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_core.sv | 99 +++++++++
 rtl/perif_uart.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the UART peripheral
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic REG_CTRL = 1'b0;
    localparam logic REG_DATA = 1'b1;

    localparam int CTRL_SEND   = 0;
    localparam int CTRL_NEW_RX = 1;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: synchroniser, RX FSM, one-cycle valid pulse
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 10417
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start was a glitch, not a frame.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    // shift_q is stable in RX_IDLE, so it is valid alongside the pulse.
    assign rx_byte_o  = shift_q;
    assign rx_valid_o = valid_q;

endmodule

// File: rtl/perif_uart.sv
// rtl/perif_uart.sv - memory-mapped UART: control/data registers, TX FSM, RX core
module perif_uart
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 10417
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_i,
    input  logic        reg_sel_i,
    input  logic [31:0] entrada_i,
    output logic [31:0] salida_o,
    input  logic        rx_i,
    output logic        tx_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             send_q, send_d;
    logic             new_rx_q, new_rx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       rx_data_q, rx_data_d;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       ctrl_wr, data_wr;
    logic       unused_entrada;

    assign ctrl_wr        = wr_i && (reg_sel_i == REG_CTRL);
    assign data_wr        = wr_i && (reg_sel_i == REG_DATA);
    assign unused_entrada = ^entrada_i[31:8];

    uart_rx_core #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rx_i      (rx_i),
        .rx_byte_o (rx_byte),
        .rx_valid_o(rx_valid)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        send_d     = send_q;
        new_rx_d   = new_rx_q;
        tx_data_d  = tx_data_q;
        rx_data_d  = rx_data_q;

        if (data_wr) begin
            tx_data_d = entrada_i[7:0];
        end

        // Hardware set of new_rx has priority over a software clear.
        if (rx_valid) begin
            new_rx_d  = 1'b1;
            rx_data_d = rx_byte;
        end else if (ctrl_wr && !entrada_i[CTRL_NEW_RX]) begin
            new_rx_d = 1'b0;
        end

        case (tx_state_q)
            TX_IDLE: begin
                tx_d     = 1'b1;
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (send_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data_q;
                    tx_d       = 1'b0;
                end else if (ctrl_wr && entrada_i[CTRL_SEND]) begin
                    send_d = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    send_d     = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            send_q     <= 1'b0;
            new_rx_q   <= 1'b0;
            tx_data_q  <= '0;
            rx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            send_q     <= send_d;
            new_rx_q   <= new_rx_d;
            tx_data_q  <= tx_data_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        salida_o = '0;
        if (reg_sel_i == REG_CTRL) begin
            salida_o[CTRL_SEND]   = send_q;
            salida_o[CTRL_NEW_RX] = new_rx_q;
        end else begin
            salida_o[7:0] = rx_data_q;
        end
    end

    assign tx_o = tx_q;

endmodule
